// File: rtl/reg_file_sb.sv
// Parametrised register file with implicit accumulator, immediate B operand and
// a single-outstanding-load scoreboard (writeback port, bypass and stall).
module reg_file_sb #(
    parameter int DW      = 8,
    parameter int AW      = 3,
    parameter int ACC_IDX = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic          mov_instr,
    input  logic          imm_val,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] dat_in,
    input  logic          ld_issue,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic [DW-1:0] dat_a_out,
    output logic [DW-1:0] dat_b_out,
    output logic          stall,
    output logic          ld_busy,
    output logic          ld_err
);

    localparam int            DEPTH = 1 << AW;
    localparam logic [AW-1:0] ACC   = AW'(ACC_IDX);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PENDING = 1'b1;

    logic [DW-1:0] core [DEPTH];
    logic [0:0]    state;
    logic [AW-1:0] pend_idx;
    logic          err_q;

    logic [AW-1:0] d_idx;
    logic          pending;
    logic          wb_fire;
    logic          hit_a;
    logic          hit_b;
    logic          wr_fire;
    logic [DW-1:0] imm_ext;

    assign d_idx   = mov_instr ? addr_a : ACC;
    assign pending = (state == PENDING);
    assign wb_fire = pending & ld_valid;

    // hit_a covers both a RAW read on A and a WAW on the destination.
    assign hit_a = (d_idx == pend_idx);
    assign hit_b = !imm_val && (addr_b == pend_idx);

    assign stall   = pending & !ld_valid & (hit_a | hit_b | ld_issue);
    assign wr_fire = wr_en & !ld_issue & !stall;

    assign ld_busy = pending;
    assign ld_err  = err_q;

    always_comb begin
        imm_ext         = '0;
        imm_ext[AW-1:0] = addr_b;
    end

    // Returning load data is forwarded to any read that targets the pending register.
    always_comb begin
        dat_a_out = core[d_idx];
        if (wb_fire && hit_a) begin
            dat_a_out = ld_data;
        end
    end

    always_comb begin
        dat_b_out = core[addr_b];
        if (imm_val) begin
            dat_b_out = imm_ext;
        end else if (wb_fire && hit_b) begin
            dat_b_out = ld_data;
        end
    end

    // The ALU write is applied after the load writeback so the younger instruction wins a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                core[i] <= '0;
            end
        end else begin
            if (wb_fire) begin
                core[pend_idx] <= ld_data;
            end
            if (wr_fire) begin
                core[d_idx] <= dat_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pend_idx <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_valid) begin
                        err_q <= 1'b1;
                    end
                    if (ld_issue) begin
                        state    <= PENDING;
                        pend_idx <= d_idx;
                    end
                end
                PENDING: begin
                    if (ld_valid) begin
                        if (ld_issue) begin
                            pend_idx <= d_idx;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios followed by random
// traffic, all compared against a behavioural register/load model.
module tb_reg_file_sb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en, mov_instr, imm_val, ld_issue, ld_valid;
    logic [2:0] addr_a, addr_b;
    logic [7:0] dat_in, ld_data;
    logic [7:0] dat_a_out, dat_b_out;
    logic       stall, ld_busy, ld_err;

    int tests_run = 0;
    int fails     = 0;

    // Reference state: register contents, whether a load is in flight, its target, error flag.
    logic [7:0] mdl [8];
    bit         m_pend;
    logic [2:0] m_idx;
    bit         m_err;

    always #5 clk = ~clk;

    reg_file_sb #(.DW(8), .AW(3), .ACC_IDX(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .mov_instr (mov_instr),
        .imm_val   (imm_val),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .dat_in    (dat_in),
        .ld_issue  (ld_issue),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .dat_a_out (dat_a_out),
        .dat_b_out (dat_b_out),
        .stall     (stall),
        .ld_busy   (ld_busy),
        .ld_err    (ld_err)
    );

    task automatic modelReset();
        for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
        m_pend = 0;
        m_idx  = 3'd0;
        m_err  = 0;
    endtask

    function automatic logic [2:0] dest();
        return mov_instr ? addr_a : 3'd0;
    endfunction

    function automatic bit expStall();
        bit conflict;
        conflict = (dest() == m_idx) || (!imm_val && addr_b == m_idx) || ld_issue;
        return m_pend && !ld_valid && conflict;
    endfunction

    function automatic logic [7:0] expA();
        if (m_pend && ld_valid && dest() == m_idx) return ld_data;
        return mdl[dest()];
    endfunction

    function automatic logic [7:0] expB();
        if (imm_val) return {5'b00000, addr_b};
        if (m_pend && ld_valid && addr_b == m_idx) return ld_data;
        return mdl[addr_b];
    endfunction

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic modelEdge();
        bit st;
        logic [2:0] d;
        st = expStall();
        d  = dest();
        if (m_pend && ld_valid) mdl[m_idx] = ld_data;
        if (wr_en && !ld_issue && !st) mdl[d] = dat_in;
        if (!m_pend) begin
            if (ld_valid) m_err = 1;
            if (ld_issue) begin
                m_pend = 1;
                m_idx  = d;
            end
        end else if (ld_valid) begin
            if (ld_issue) m_idx = d;
            else m_pend = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, ".dat_a"}, dat_a_out, expA());
        chk({tag, ".dat_b"}, dat_b_out, expB());
        chk({tag, ".stall"}, {7'd0, stall}, {7'd0, expStall()});
        chk({tag, ".ld_busy"}, {7'd0, ld_busy}, {7'd0, m_pend});
        chk({tag, ".ld_err"}, {7'd0, ld_err}, {7'd0, m_err});
    endtask

    task automatic applyStimulus(input logic we, input logic mov, input logic imm,
                                 input logic [2:0] a, input logic [2:0] b, input logic [7:0] din,
                                 input logic iss, input logic vld, input logic [7:0] ldd);
        wr_en = we; mov_instr = mov; imm_val = imm; addr_a = a; addr_b = b;
        dat_in = din; ld_issue = iss; ld_valid = vld; ld_data = ldd;
    endtask

    // Check the settled outputs, then clock once and update the model.
    task automatic clockStep(input string tag);
        #2;
        checkOutput(tag);
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic readAll(input string tag);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 0, 3'd0, 3'(i), 8'h00, 0, 0, 8'h00);
            clockStep($sformatf("%s_r%0d", tag, i));
        end
    endtask

    initial begin
        applyStimulus(0, 0, 0, 3'd0, 3'd0, 8'h00, 0, 0, 8'h00);
        rst_n = 1'b0;
        modelReset();
        #3;
        checkOutput("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        applyStimulus(1, 1, 0, 3'd3, 3'd3, 8'hA5, 0, 0, 8'h00);
        clockStep("wr_r3");
        applyStimulus(0, 1, 0, 3'd3, 3'd3, 8'h00, 0, 0, 8'h00);
        clockStep("rd_r3");
        // Asynchronous clear in the middle of a cycle, no clock edge involved.
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("async_clr");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(1, 0, 0, 3'd5, 3'd0, 8'h12, 0, 0, 8'h00);
        clockStep("acc_wr");
        applyStimulus(0, 0, 0, 3'd5, 3'd0, 8'h00, 0, 0, 8'h00);
        clockStep("acc_rd");
        applyStimulus(0, 1, 0, 3'd5, 3'd5, 8'h00, 0, 0, 8'h00);
        clockStep("mov_rd");
        applyStimulus(0, 1, 1, 3'd5, 3'd6, 8'h00, 0, 0, 8'h00);
        clockStep("imm_rd");
        chk("imm_value", dat_b_out, 8'h06);

        applyStimulus(0, 1, 0, 3'd2, 3'd0, 8'h00, 1, 0, 8'h00);
        clockStep("raw_issue");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 3'd0, 3'd2, 8'h5A, 0, 0, 8'h00);
            #2;
            chk($sformatf("raw_stall%0d", i), {7'd0, stall}, 8'h01);
            clockStep($sformatf("raw_wait%0d", i));
        end
        applyStimulus(0, 0, 0, 3'd0, 3'd2, 8'h00, 0, 1, 8'h7C);
        #2;
        chk("raw_bypass", dat_b_out, 8'h7C);
        clockStep("raw_ret");
        applyStimulus(0, 1, 0, 3'd2, 3'd2, 8'h00, 0, 0, 8'h00);
        clockStep("raw_after");

        applyStimulus(0, 1, 0, 3'd1, 3'd0, 8'h00, 1, 0, 8'h00);
        clockStep("b2b_issue1");
        applyStimulus(0, 1, 0, 3'd4, 3'd0, 8'h00, 1, 1, 8'h11);
        clockStep("b2b_issue2");
        applyStimulus(0, 1, 0, 3'd5, 3'd3, 8'h00, 1, 0, 8'h00);
        clockStep("b2b_stall");
        applyStimulus(0, 1, 0, 3'd1, 3'd1, 8'h00, 0, 1, 8'h44);
        clockStep("b2b_ret");
        applyStimulus(0, 1, 0, 3'd4, 3'd1, 8'h00, 0, 0, 8'h00);
        clockStep("b2b_after");

        applyStimulus(0, 1, 0, 3'd6, 3'd0, 8'h00, 1, 0, 8'h00);
        clockStep("waw_issue");
        applyStimulus(1, 1, 0, 3'd6, 3'd0, 8'h33, 0, 1, 8'h99);
        clockStep("waw_collide");
        applyStimulus(0, 1, 0, 3'd6, 3'd0, 8'h00, 0, 0, 8'h00);
        clockStep("waw_after");
        chk("waw_value", dat_a_out, 8'h33);
        applyStimulus(0, 1, 0, 3'd6, 3'd0, 8'h00, 1, 0, 8'h00);
        clockStep("waw_issue2");
        applyStimulus(1, 1, 0, 3'd6, 3'd0, 8'h55, 0, 0, 8'h00);
        clockStep("waw_stall");
        applyStimulus(0, 1, 0, 3'd6, 3'd0, 8'h00, 0, 0, 8'h00);
        clockStep("waw_hold");
        applyStimulus(0, 1, 0, 3'd6, 3'd0, 8'h00, 0, 1, 8'h77);
        clockStep("waw_ret");

        applyStimulus(0, 1, 0, 3'd7, 3'd7, 8'h00, 0, 1, 8'hEE);
        clockStep("err_valid");
        applyStimulus(0, 1, 0, 3'd7, 3'd7, 8'h00, 0, 0, 8'h00);
        clockStep("err_after");
        applyStimulus(0, 1, 0, 3'd3, 3'd0, 8'h00, 1, 0, 8'h00);
        clockStep("rst_issue");
        applyStimulus(0, 0, 0, 3'd0, 3'd0, 8'h00, 0, 0, 8'h00);
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_pending");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        readAll("rst_clear");
        applyStimulus(0, 0, 0, 3'd3, 3'd3, 8'h00, 0, 1, 8'hC3);
        clockStep("late_valid");
        applyStimulus(0, 1, 0, 3'd3, 3'd3, 8'h00, 0, 0, 8'h00);
        clockStep("late_after");

        // Random traffic; load returns are biased to arrive while a load is pending.
        for (int n = 0; n < 400; n++) begin
            logic vld;
            vld = m_pend ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0);
            applyStimulus(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                          3'($urandom), 3'($urandom), 8'($urandom),
                          ($urandom_range(0, 4) == 0), vld, 8'($urandom));
            clockStep($sformatf("rand%0d", n));
        end
        readAll("final");

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the 8-bit accumulator-style register file.
- Keeps the accumulator/mov/immediate read-write semantics and adds:
  - asynchronous clear of the whole array;
  - a single-outstanding-load scoreboard with writeback port, bypass and stall generation.
- Sits between decode and ALU.
- Load-return data from data memory arrives on a separate writeback port, several cycles after issue.

Parameters:
- DW, 8: data width of each register.
- AW, 3: address width; depth = 2**AW. Requires AW <= DW.
- ACC_IDX, 0: index of the implicit accumulator register.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  register write request for the current instruction.
- mov_instr  input  1  1: destination/read-A index = addr_a; 0: index = ACC_IDX.
- imm_val  input  1  1: port B returns zero-extended addr_b instead of a register.
- addr_a  input  AW  explicit register index for A/destination.
- addr_b  input  AW  register index or immediate for B.
- dat_in  input  DW  write data from ALU.
- ld_issue  input  1  current instruction is a load targeting index D.
- ld_valid  input  1  load data return strobe, one cycle.
- ld_data  input  DW  load return data.
- dat_a_out  output  DW  read data A (combinational).
- dat_b_out  output  DW  read data B (combinational).
- stall  output  1  hold current instruction; no state update from it this cycle.
- ld_busy  output  1  a load is outstanding (state PENDING).
- ld_err  output  1  sticky: ld_valid seen while IDLE.

Behaviour:

Index and read paths:
- D = mov_instr ? addr_a : ACC_IDX.
- A read index = D.
- B read: imm_val ? {zeros, addr_b} : core[addr_b].
- Reads are combinational.

Reset (rst_n low, async):
- All core entries = 0; state = IDLE; pend_idx = 0; ld_err = 0.
- Outputs while in reset: ld_busy = 0, stall = 0; dat_a_out/dat_b_out reflect cleared array (0, or the immediate on B).
- Reset mid-load discards the outstanding load. A later ld_valid then sets ld_err.

FSM:
- IDLE, ld_issue → PENDING; pend_idx <= D.
- PENDING, ld_valid & !ld_issue → IDLE; core[pend_idx] <= ld_data.
- PENDING, ld_valid & ld_issue → stay PENDING (back-to-back): write ld_data to old pend_idx; pend_idx <= D.
- PENDING, !ld_valid → stay PENDING.
- IDLE, ld_valid → ignored; ld_err <= 1.
- ld_busy = (state == PENDING).

Bypass, valid only while PENDING and ld_valid:
- Any read selecting pend_idx returns ld_data this cycle (A, and B when !imm_val).

Stall:
- stall = PENDING & !ld_valid & (hitA | hitB | ld_issue).
- hitA = (D == pend_idx). This covers both RAW on A and WAW on the destination.
- hitB = !imm_val & (addr_b == pend_idx).
- While stall = 1: no core write from wr_en and no FSM capture from ld_issue. The instruction is presented again next cycle.

Writes (rising edge):
- If wr_en & !ld_issue & !stall: core[D] <= dat_in.
- ld_issue takes priority over wr_en; no dat_in write on a load.
- Same cycle, same index: load writeback to pend_idx plus wr_en write to D == pend_idx → wr_en value wins (younger instruction).
- Different indices: both writes occur.

Latency:
- Read: 0 cycles.
- Write: visible on the read ports the cycle after the edge.
- Load: visible via bypass in the ld_valid cycle, and from the array afterwards.

Width: immediate is zero-extended from AW to DW; no sign extension.

Test Plan:
- Reset and clear: write 8'hA5 to r3 (mov_instr=1, addr_a=3). Pulse rst_n low mid-cycle → dat_a_out reads 0 immediately, without waiting for a clock edge; ld_busy=0; stall=0.
- Accumulator vs mov vs immediate: mov_instr=0, wr_en, dat_in=8'h12 → r0=8'h12. Then read mov_instr=1, addr_a=5 → r5. Then imm_val=1, addr_b=3'd6 → dat_b_out=8'h06.
- RAW stall and bypass: ld_issue with D=2. Next cycle read addr_b=2 → stall=1 for 3 cycles. Then ld_valid with ld_data=8'h7C → stall=0 and dat_b_out=8'h7C that cycle. Afterwards r2=8'h7C and ld_busy=0.
- Back-to-back loads: load to r1 pending; ld_issue (D=4) and ld_valid (8'h11) in the same cycle → r1=8'h11, pend_idx=4, ld_busy stays 1. A second ld_issue without ld_valid stalls.
- WAW collision: load to r6 pending. wr_en to r6 with dat_in=8'h33 in the same cycle as ld_valid with 8'h99 → r6=8'h33. wr_en to r6 without ld_valid → stall=1 and r6 unchanged.
- Error and reset mid-load: ld_valid in IDLE → ld_err=1, no write. Assert rst_n while PENDING → IDLE, ld_err=0, all registers 0.
